// File: rtl/hash_arbiter_if.sv
// Requester-side and core-side signal bundle for the shared SHAKE core arbiter.
// The slave modport is the arbiter view; the master modport is the environment view.
interface hash_arbiter_if #(
    parameter int N_REQ      = 3,
    parameter int IO_WIDTH   = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [N_REQ-1:0]          i_req_start;
    logic [N_REQ*32-1:0]       i_req_input_length;
    logic [N_REQ*32-1:0]       i_req_output_length;
    logic [N_REQ*IO_WIDTH-1:0] i_req_data_in;
    logic [ADDR_WIDTH-1:0]     o_req_addr;
    logic [N_REQ-1:0]          o_req_rd_en;
    logic [IO_WIDTH-1:0]       o_req_data_out;
    logic [N_REQ-1:0]          o_req_data_out_valid;
    logic [N_REQ-1:0]          i_req_data_out_ready;
    logic [N_REQ-1:0]          i_req_force_done;
    logic [N_REQ-1:0]          o_req_force_done_ack;
    logic [N_REQ-1:0]          o_grant;
    logic                      o_busy;
    logic [IO_WIDTH-1:0]       o_hash_data_in;
    logic [31:0]               o_hash_input_length;
    logic [31:0]               o_hash_output_length;
    logic                      o_hash_start;
    logic                      o_hash_data_out_ready;
    logic                      o_hash_force_done;
    logic [ADDR_WIDTH-1:0]     i_hash_addr;
    logic                      i_hash_rd_en;
    logic [IO_WIDTH-1:0]       i_hash_data_out;
    logic                      i_hash_data_out_valid;
    logic                      i_hash_force_done_ack;

    modport slave (
        input  i_req_start, i_req_input_length, i_req_output_length, i_req_data_in,
               i_req_data_out_ready, i_req_force_done,
               i_hash_addr, i_hash_rd_en, i_hash_data_out, i_hash_data_out_valid,
               i_hash_force_done_ack,
        output o_req_addr, o_req_rd_en, o_req_data_out, o_req_data_out_valid,
               o_req_force_done_ack, o_grant, o_busy,
               o_hash_data_in, o_hash_input_length, o_hash_output_length, o_hash_start,
               o_hash_data_out_ready, o_hash_force_done
    );

    modport master (
        output i_req_start, i_req_input_length, i_req_output_length, i_req_data_in,
               i_req_data_out_ready, i_req_force_done,
               i_hash_addr, i_hash_rd_en, i_hash_data_out, i_hash_data_out_valid,
               i_hash_force_done_ack,
        input  o_req_addr, o_req_rd_en, o_req_data_out, o_req_data_out_valid,
               o_req_force_done_ack, o_grant, o_busy,
               o_hash_data_in, o_hash_input_length, o_hash_output_length, o_hash_start,
               o_hash_data_out_ready, o_hash_force_done
    );
endinterface

// File: rtl/hash_arbiter.sv
// Round-robin arbiter sharing one SHAKE core among N_REQ requesters.
// Only grant, state, pending and the round-robin pointer are registered; routing is combinational.
module hash_arbiter #(
    parameter int N_REQ      = 3,
    parameter int IO_WIDTH   = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    hash_arbiter_if.slave  bus
);
    localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LAUNCH  = 2'd1;
    localparam logic [1:0] BUSY    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [1:0]       state_r, state_nxt_s;
    logic [N_REQ-1:0] grant_r, grant_nxt_s;
    logic [N_REQ-1:0] pend_r, pend_nxt_s;
    logic [RR_W-1:0]  rr_r, rr_nxt_s;

    logic [RR_W-1:0]  owner_s;
    logic [N_REQ-1:0] req_vec_s;
    logic [N_REQ-1:0] pick_s;
    logic             active_s;
    logic             in_busy_s;
    logic             in_release_s;
    logic             owner_done_s;

    assign req_vec_s    = pend_r | bus.i_req_start;
    assign active_s     = (state_r != IDLE);
    assign in_busy_s    = (state_r == BUSY);
    assign in_release_s = (state_r == RELEASE);
    assign owner_done_s = |(bus.i_req_force_done & grant_r);

    // Encode the one-hot grant into an owner index used for slice selection.
    always_comb begin
        owner_s = {RR_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            owner_s = owner_s | (grant_r[i] ? RR_W'(i) : {RR_W{1'b0}});
        end
    end

    // Round-robin pick: first requesting bit at or after rr, wrapping.
    always_comb begin
        logic found;
        logic hit;
        int   idx;
        pick_s = {N_REQ{1'b0}};
        found  = 1'b0;
        hit    = 1'b0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx         = int'(rr_r) + i;
            idx         = (idx >= N_REQ) ? (idx - N_REQ) : idx;
            hit         = !found && req_vec_s[idx];
            pick_s[idx] = pick_s[idx] | hit;
            found       = found | hit;
        end
    end

    // Next-state, grant and pointer decisions.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        rr_nxt_s    = rr_r;
        case (state_r)
            IDLE: begin
                if (|req_vec_s) begin
                    grant_nxt_s = pick_s;
                    state_nxt_s = LAUNCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LAUNCH: begin
                state_nxt_s = BUSY;
            end
            BUSY: begin
                if (owner_done_s) begin
                    state_nxt_s = RELEASE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            RELEASE: begin
                if (bus.i_hash_force_done_ack) begin
                    rr_nxt_s    = (int'(owner_s) == N_REQ - 1) ? {RR_W{1'b0}} : owner_s + RR_W'(1);
                    grant_nxt_s = {N_REQ{1'b0}};
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RELEASE;
                end
            end
            default: begin
                grant_nxt_s = {N_REQ{1'b0}};
                state_nxt_s = IDLE;
            end
        endcase
    end

    // A start from the current owner is dropped; the owner's pending bit clears at launch.
    always_comb begin
        pend_nxt_s = pend_r | (bus.i_req_start & ~grant_r);
        if (state_r == LAUNCH) begin
            pend_nxt_s = pend_nxt_s & ~grant_r;
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            grant_r <= {N_REQ{1'b0}};
            pend_r  <= {N_REQ{1'b0}};
            rr_r    <= {RR_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            pend_r  <= pend_nxt_s;
            rr_r    <= rr_nxt_s;
        end
    end

    assign bus.o_grant             = grant_r;
    assign bus.o_busy              = active_s;
    assign bus.o_hash_start        = (state_r == LAUNCH);
    assign bus.o_hash_force_done   = in_release_s;
    assign bus.o_hash_input_length  = active_s ? bus.i_req_input_length[int'(owner_s)*32 +: 32]  : 32'd0;
    assign bus.o_hash_output_length = active_s ? bus.i_req_output_length[int'(owner_s)*32 +: 32] : 32'd0;
    assign bus.o_hash_data_in      = active_s ? bus.i_req_data_in[int'(owner_s)*IO_WIDTH +: IO_WIDTH]
                                              : {IO_WIDTH{1'b0}};

    // Core return traffic reaches only the owner while a job runs.
    assign bus.o_req_addr            = active_s  ? bus.i_hash_addr     : {ADDR_WIDTH{1'b0}};
    assign bus.o_req_data_out        = active_s  ? bus.i_hash_data_out : {IO_WIDTH{1'b0}};
    assign bus.o_req_rd_en           = in_busy_s ? (grant_r & {N_REQ{bus.i_hash_rd_en}})          : {N_REQ{1'b0}};
    assign bus.o_req_data_out_valid  = in_busy_s ? (grant_r & {N_REQ{bus.i_hash_data_out_valid}}) : {N_REQ{1'b0}};
    assign bus.o_hash_data_out_ready = in_busy_s & (|(bus.i_req_data_out_ready & grant_r));
    assign bus.o_req_force_done_ack  = (in_release_s && bus.i_hash_force_done_ack) ? grant_r : {N_REQ{1'b0}};
endmodule

// File: tb/tb_hash_arbiter.sv
// Directed self-checking bench for hash_arbiter: a launch monitor pops the expected owner
// queue on every core start pulse; directed steps check routing, release and reset.
module tb_hash_arbiter;
    localparam int N = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hash_arbiter_if #(.N_REQ(N), .IO_WIDTH(32), .ADDR_WIDTH(10)) bus();

    hash_arbiter #(.N_REQ(N), .IO_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int          total  = 0;
    int          passed = 0;
    int          exp_q[$];
    logic [31:0] ilen_m[N];
    logic [31:0] olen_m[N];
    logic [31:0] data_m[N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_lens();
        for (int k = 0; k < N; k++) begin
            bus.i_req_input_length[k*32 +: 32]  = ilen_m[k];
            bus.i_req_output_length[k*32 +: 32] = olen_m[k];
            bus.i_req_data_in[k*32 +: 32]       = data_m[k];
        end
    endtask

    task automatic clear_inputs();
        bus.i_req_start           = 3'b000;
        bus.i_req_data_out_ready  = 3'b000;
        bus.i_req_force_done      = 3'b000;
        bus.i_hash_addr           = 10'd0;
        bus.i_hash_rd_en          = 1'b0;
        bus.i_hash_data_out       = 32'd0;
        bus.i_hash_data_out_valid = 1'b0;
        bus.i_hash_force_done_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        chk("rst_grant", bus.o_grant, 64'd0);
        chk("rst_busy", bus.o_busy, 64'd0);
        chk("rst_start", bus.o_hash_start, 64'd0);
        chk("rst_ilen", bus.o_hash_input_length, 64'd0);
        chk("rst_ack", bus.o_req_force_done_ack, 64'd0);
        rst_n = 1'b1;
        step();
    endtask

    // Wait (bounded) for a launch, then advance into BUSY.
    task automatic wait_start(input string tag);
        int n = 0;
        while (bus.o_hash_start !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_launch"}, bus.o_hash_start, 64'd1);
        step();
        chk({tag, "_start_one_cycle"}, bus.o_hash_start, 64'd0);
        chk({tag, "_busy"}, bus.o_busy, 64'd1);
    endtask

    // From BUSY: owner requests release, core acks after dly cycles; sa is driven on the ack cycle.
    task automatic finish_job(input int idx, input logic [N-1:0] sa, input int dly);
        logic [N-1:0] own;
        own = 3'b001 << idx;
        bus.i_req_force_done = own;
        step();
        bus.i_req_force_done = 3'b000;
        for (int i = 0; i < dly; i++) begin
            chk("rel_force_done_held", bus.o_hash_force_done, 64'd1);
            chk("rel_no_early_ack", bus.o_req_force_done_ack, 64'd0);
            step();
        end
        chk("rel_force_done", bus.o_hash_force_done, 64'd1);
        bus.i_hash_force_done_ack = 1'b1;
        bus.i_req_start           = sa;
        #1;
        chk("rel_ack_owner", bus.o_req_force_done_ack, own);
        step();
        bus.i_hash_force_done_ack = 1'b0;
        bus.i_req_start           = 3'b000;
        #1;
        chk("rel_idle_gap", bus.o_busy, 64'd0);
        chk("rel_ack_single", bus.o_req_force_done_ack, 64'd0);
        chk("rel_force_done_low", bus.o_hash_force_done, 64'd0);
    endtask

    // Scoreboard: each core start must match the next expected owner and its lengths.
    always @(negedge clk) begin : launch_monitor
        int e;
        if (rst_n === 1'b1 && bus.o_hash_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_start", bus.o_hash_start, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("grant_order", bus.o_grant, 64'(3'b001 << e));
                chk("launch_ilen", bus.o_hash_input_length, 64'(ilen_m[e]));
                chk("launch_olen", bus.o_hash_output_length, 64'(olen_m[e]));
            end
        end
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            ilen_m[k] = 32'h100 * (k + 1);
            olen_m[k] = 32'd256 * (k + 1);
            data_m[k] = 32'hD000_0000 + k;
        end
        ilen_m[1] = 32'h1400;
        olen_m[1] = 32'd512;
        load_lens();
        do_reset();

        // Single job for requester 1
        exp_q.push_back(1);
        bus.i_req_start = 3'b010;
        step();
        bus.i_req_start = 3'b000;
        chk("t1_grant", bus.o_grant, 64'h2);
        chk("t1_start", bus.o_hash_start, 64'd1);
        chk("t1_ilen", bus.o_hash_input_length, 64'h1400);
        chk("t1_olen", bus.o_hash_output_length, 64'd512);
        step();
        chk("t1_start_drop", bus.o_hash_start, 64'd0);
        chk("t1_data_in", bus.o_hash_data_in, 64'(data_m[1]));
        bus.i_hash_addr           = 10'h155;
        bus.i_hash_rd_en          = 1'b1;
        bus.i_hash_data_out       = 32'hCAFE_0001;
        bus.i_hash_data_out_valid = 1'b1;
        bus.i_req_data_out_ready  = 3'b101;
        #1;
        chk("t1_rd_en", bus.o_req_rd_en, 64'h2);
        chk("t1_addr", bus.o_req_addr, 64'h155);
        chk("t1_valid", bus.o_req_data_out_valid, 64'h2);
        chk("t1_digest", bus.o_req_data_out, 64'hCAFE_0001);
        chk("t1_ready_foreign", bus.o_hash_data_out_ready, 64'd0);
        bus.i_req_data_out_ready = 3'b010;
        #1;
        chk("t1_ready_owner", bus.o_hash_data_out_ready, 64'd1);
        clear_inputs();
        finish_job(1, 3'b000, 0);
        chk("t1_grant_clear", bus.o_grant, 64'd0);
        chk("t1_ilen_idle", bus.o_hash_input_length, 64'd0);

        // Contention from reset: 0, 1, 2 in order with one idle cycle between jobs
        do_reset();
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        bus.i_req_start = 3'b111;
        step();
        bus.i_req_start = 3'b000;
        wait_start("c0");
        finish_job(0, 3'b000, 0);
        wait_start("c1");
        finish_job(1, 3'b000, 0);
        wait_start("c2");
        finish_job(2, 3'b000, 0);

        // Fairness: 0 re-requests after its ack while 2 is pending
        exp_q.push_back(0);
        bus.i_req_start = 3'b001;
        step();
        bus.i_req_start = 3'b000;
        wait_start("f0");
        exp_q.push_back(2);
        bus.i_req_start = 3'b100;
        step();
        bus.i_req_start = 3'b000;
        finish_job(0, 3'b000, 0);
        exp_q.push_back(0);
        bus.i_req_start = 3'b001;
        step();
        bus.i_req_start = 3'b000;
        wait_start("f2");
        // Owner 2 start on its ack cycle is dropped, requester 1 start is latched
        exp_q.push_back(1);
        finish_job(2, 3'b110, 0);
        wait_start("f0b");
        finish_job(0, 3'b000, 0);
        wait_start("f1");
        finish_job(1, 3'b000, 0);
        repeat (4) step();
        chk("f_no_dropped_job", bus.o_busy, 64'd0);

        // Duplicate owner start and foreign force_done while busy
        exp_q.push_back(2);
        bus.i_req_start = 3'b100;
        step();
        bus.i_req_start = 3'b000;
        wait_start("d2");
        bus.i_req_start      = 3'b100;
        bus.i_req_force_done = 3'b001;
        step();
        bus.i_req_start      = 3'b000;
        bus.i_req_force_done = 3'b000;
        chk("d_grant_kept", bus.o_grant, 64'h4);
        chk("d_force_done_low", bus.o_hash_force_done, 64'd0);
        step();
        chk("d_still_busy", bus.o_busy, 64'd1);
        chk("d_force_done_low2", bus.o_hash_force_done, 64'd0);
        finish_job(2, 3'b000, 0);
        repeat (4) step();
        chk("d_no_extra_job", bus.o_busy, 64'd0);

        // Delayed core ack
        exp_q.push_back(0);
        bus.i_req_start = 3'b001;
        step();
        bus.i_req_start = 3'b000;
        wait_start("a0");
        finish_job(0, 3'b000, 5);

        // Asynchronous reset mid-BUSY with two pending
        exp_q.push_back(0);
        bus.i_req_start = 3'b001;
        step();
        bus.i_req_start = 3'b000;
        wait_start("r0");
        bus.i_req_start = 3'b110;
        step();
        bus.i_req_start           = 3'b000;
        bus.i_hash_rd_en          = 1'b1;
        bus.i_hash_data_out_valid = 1'b1;
        bus.i_hash_addr           = 10'h2AA;
        bus.i_hash_data_out       = 32'h1234_5678;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_grant", bus.o_grant, 64'd0);
        chk("ar_busy", bus.o_busy, 64'd0);
        chk("ar_rd_en", bus.o_req_rd_en, 64'd0);
        chk("ar_valid", bus.o_req_data_out_valid, 64'd0);
        chk("ar_addr", bus.o_req_addr, 64'd0);
        chk("ar_data_out", bus.o_req_data_out, 64'd0);
        chk("ar_ilen", bus.o_hash_input_length, 64'd0);
        clear_inputs();
        step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("ar_no_grant", bus.o_grant, 64'd0);
        chk("ar_idle", bus.o_busy, 64'd0);
        exp_q.push_back(1);
        bus.i_req_start = 3'b010;
        step();
        bus.i_req_start = 3'b000;
        wait_start("ar1");
        finish_job(1, 3'b000, 0);

        repeat (3) step();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hash_arbiter.md
# hash_arbiter

Round-robin arbiter and sequencer that shares the single SHAKE hash core (`hash_mem_interface`) among several signing-path requesters (hash_1, hash_2, expansion blocks). Each requester sees a private copy of the core handshake. The arbiter latches start pulses, grants one owner at a time, and forwards that owner's lengths and start to the core. It routes memory, output and force-done traffic only between the owner and the core, and releases the core once the force-done/ack handshake completes.

## Interface
- `N_REQ`, 3: number of requesters (2..8).
- `IO_WIDTH`, 32: hash data-path width.
- `ADDR_WIDTH`, 10: core input-memory address width.
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_req_start`  in  N_REQ  per-requester start pulse.
- `i_req_input_length`  in  N_REQ*32  per-requester input length in bits; slice k = bits [32k+31:32k].
- `i_req_output_length`  in  N_REQ*32  per-requester output length in bits.
- `i_req_data_in`  in  N_REQ*IO_WIDTH  per-requester message word.
- `o_req_addr`  out  ADDR_WIDTH  core read address, broadcast to all requesters.
- `o_req_rd_en`  out  N_REQ  core read enable, owner bit only.
- `o_req_data_out`  out  IO_WIDTH  core digest word, broadcast.
- `o_req_data_out_valid`  out  N_REQ  digest valid, owner bit only.
- `i_req_data_out_ready`  in  N_REQ  per-requester digest ready.
- `i_req_force_done`  in  N_REQ  per-requester release request.
- `o_req_force_done_ack`  out  N_REQ  release ack pulse.
- `o_grant`  out  N_REQ  one-hot current owner; zero when idle.
- `o_busy`  out  1  high in every state except IDLE.
- `o_hash_data_in`, `o_hash_input_length`, `o_hash_output_length`, `o_hash_start`, `o_hash_data_out_ready`, `o_hash_force_done`  out: core-side copies of the owner's signals.
- `i_hash_addr`, `i_hash_rd_en`, `i_hash_data_out`, `i_hash_data_out_valid`, `i_hash_force_done_ack`  in: core-side returns.

## Operation
- **State machine:** IDLE, LAUNCH, BUSY, RELEASE.
- **Pending register `pend[N_REQ]`:**
  - A bit sets on `i_req_start[k]`, unless k is already pending or is the current owner. In those cases the pulse is dropped.
  - A bit clears when that requester is granted.
- **IDLE:**
  - Request vector is `pend | i_req_start`.
  - If nonzero, pick the first set bit at or after pointer `rr`, wrapping modulo N_REQ.
  - Register `grant` one-hot and go to LAUNCH.
- **LAUNCH (exactly one cycle):**
  - `o_hash_start` = 1.
  - Lengths driven from the owner's slices.
  - Clear `pend[owner]`, then go to BUSY.
- **BUSY:**
  - Combinational routing: `o_hash_data_in` = owner slice.
  - `o_req_rd_en[owner]` = `i_hash_rd_en`.
  - `o_req_data_out_valid[owner]` = `i_hash_data_out_valid`.
  - `o_hash_data_out_ready` = `i_req_data_out_ready[owner]`.
  - Non-owner rd_en, valid and ack bits are 0.
  - `i_req_force_done[owner]` = 1 moves to RELEASE.
  - Non-owner force_done is ignored.
- **RELEASE:**
  - `o_hash_force_done` = 1 until `i_hash_force_done_ack` = 1.
  - On that ack cycle, `o_req_force_done_ack[owner]` = 1 for one cycle.
  - Set `rr` = (owner+1) mod N_REQ, clear `grant`, go to IDLE.
- **Lengths:** `o_hash_input_length` and `o_hash_output_length` are held from the owner's slices in LAUNCH, BUSY and RELEASE. They are 0 in IDLE.

## Timing
- **Reset:** all outputs 0, `pend` = 0, `rr` = 0, state IDLE.
  - Reset mid-transfer abandons the core. The integrator resets core and arbiter together.
- **Start latency:** `i_req_start[k]` sampled at edge t in IDLE gives `o_grant[k]` = 1 and `o_hash_start` = 1 during cycle t+1. BUSY begins at t+2.
- **Back-to-back:** a pending request is granted on the edge after the IDLE cycle that follows the ack, so the core is idle for 1 cycle between jobs.
- **Simultaneous starts:** all are latched. They are served in round-robin order from `rr`.
- **Simultaneous start and release:**
  - A start from the owner in the same cycle as its ack is dropped.
  - A start from any other requester in that cycle is latched.
- **Routing latency:** all BUSY-phase routing is combinational, zero cycles. Only `grant`, state, `pend` and `rr` are registered.

## Test plan
- Single job:
  - Stimulus: reset, then `i_req_start` = 3'b010 with input length 0x1400 and output length 512.
  - Required: `o_grant` = 010 and `o_hash_start` for 1 cycle; `o_hash_input_length` = 0x1400; digest words reach requester 1 only; ack follows force_done; `o_busy` drops.
- Contention:
  - Stimulus: starts 3'b111 in the same cycle from reset.
  - Required: grants 001, 010, 100 in order, with exactly 3 `o_hash_start` pulses.
- Round-robin fairness:
  - Stimulus: requester 0 re-requests immediately after each ack while 2 is pending.
  - Required: after 0's job, 2 is granted before 0 again.
- Duplicate and foreign pulses:
  - Stimulus: owner pulses start in BUSY; a non-owner pulses force_done.
  - Required: no extra job, no state change, `o_hash_force_done` stays 0.
- Delayed ack:
  - Stimulus: core holds `i_hash_force_done_ack` low for 5 cycles in RELEASE.
  - Required: `o_hash_force_done` stays high for 5 cycles; a single ack pulse on the ack cycle.
- Async reset:
  - Stimulus: `i_rst_n` low mid-BUSY with 2 pending.
  - Required: all outputs 0 immediately; after release, no grant until a new start.
